// File: rtl/cblp_pkg.sv
// Shared types for the push-button step counter:
// FSM states, step direction and a timer width helper.
package cblp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    // Bits needed for a counter that runs 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-FF synchroniser followed by a stability counter
// that accepts a new level only after DEBOUNCE_CYCLES agreeing samples.
module btn_debounce
    import cblp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int W = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]   sync;
    logic [W-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync    <= '0;
            cnt     <= '0;
            o_level <= 1'b0;
        end else begin
            sync <= {sync[0], i_raw};
            if (sync[1] == o_level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                o_level <= ~o_level;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_step_counter.sv
// Debounced up/down/clear step counter with wrap or saturate,
// hold-to-auto-repeat and a registered one-hot decode of the count.
module btn_step_counter
    import cblp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_MAX         = 7,
    parameter int CNT_W           = 3,
    parameter int WRAP            = 1,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_btn_up,
    input  logic               i_btn_dn,
    input  logic               i_btn_clr,
    output logic [CNT_W-1:0]   o_count,
    output logic [CNT_MAX:0]   o_onehot,
    output logic               o_led,
    output logic               o_step,
    output logic               o_wrap
);

    localparam int OH_W = CNT_MAX + 1;
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = cnt_w(TMAX);
    localparam logic [TW-1:0] HOLD_LAST =
        TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [TW-1:0] RPT_LAST = TW'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] TOP = CNT_W'(CNT_MAX);
    localparam bit AUTO  = (REPEAT_DELAY > 0);
    localparam bit DO_WR = (WRAP != 0);

    logic lvl_up, lvl_dn, lvl_clr;
    logic lvl_up_q, lvl_dn_q, lvl_clr_q;
    logic rise_up, rise_dn, rise_clr;

    state_t          state;
    dir_t            dir;
    dir_t            fire_dir;
    logic [TW-1:0]   timer;
    logic            held;
    logic            fire;
    logic [CNT_W-1:0] nxt;
    logic            nstep;
    logic            nwrap;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_btn_up),
        .o_level (lvl_up)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_btn_dn),
        .o_level (lvl_dn)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_raw   (i_btn_clr),
        .o_level (lvl_clr)
    );

    assign rise_up  = lvl_up  & ~lvl_up_q;
    assign rise_dn  = lvl_dn  & ~lvl_dn_q;
    assign rise_clr = lvl_clr & ~lvl_clr_q;
    assign o_led    = lvl_up | lvl_dn | lvl_clr;

    // Opposite-direction presses are ignored once a hold is in progress.
    always_comb begin
        held     = (dir == DIR_UP) ? lvl_up : lvl_dn;
        fire     = 1'b0;
        fire_dir = dir;
        unique case (state)
            IDLE: begin
                if (rise_up ^ rise_dn) begin
                    fire     = 1'b1;
                    fire_dir = rise_dn ? DIR_DN : DIR_UP;
                end
            end
            HOLD:    fire = held && (timer == HOLD_LAST);
            REPEAT:  fire = held && (timer == RPT_LAST);
            default: fire = 1'b0;
        endcase
    end

    always_comb begin
        nxt   = o_count;
        nstep = 1'b0;
        nwrap = 1'b0;
        if (fire) begin
            if (fire_dir == DIR_UP) begin
                if (o_count != TOP) begin
                    nxt   = o_count + 1'b1;
                    nstep = 1'b1;
                end else if (DO_WR) begin
                    nxt   = '0;
                    nstep = 1'b1;
                    nwrap = 1'b1;
                end
            end else begin
                if (o_count != '0) begin
                    nxt   = o_count - 1'b1;
                    nstep = 1'b1;
                end else if (DO_WR) begin
                    nxt   = TOP;
                    nstep = 1'b1;
                    nwrap = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lvl_up_q  <= 1'b0;
            lvl_dn_q  <= 1'b0;
            lvl_clr_q <= 1'b0;
            state     <= IDLE;
            dir       <= DIR_UP;
            timer     <= '0;
            o_count   <= '0;
            o_onehot  <= OH_W'(1);
            o_step    <= 1'b0;
            o_wrap    <= 1'b0;
        end else begin
            lvl_up_q  <= lvl_up;
            lvl_dn_q  <= lvl_dn;
            lvl_clr_q <= lvl_clr;
            if (rise_clr) begin
                state    <= IDLE;
                timer    <= '0;
                o_count  <= '0;
                o_onehot <= OH_W'(1);
                o_step   <= (o_count != '0);
                o_wrap   <= 1'b0;
            end else begin
                o_count  <= nxt;
                o_onehot <= OH_W'(1) << nxt;
                o_step   <= nstep;
                o_wrap   <= nwrap;
                unique case (state)
                    IDLE: begin
                        if (fire && AUTO) begin
                            dir   <= fire_dir;
                            timer <= '0;
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (!held) begin
                            state <= IDLE;
                        end else if (timer == HOLD_LAST) begin
                            timer <= '0;
                            state <= REPEAT;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!held) begin
                            state <= IDLE;
                        end else if (timer == RPT_LAST) begin
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btn_step_counter.sv
// Bench for btn_step_counter: a wrapping and a saturating instance share
// the button stimulus and are both tracked by a behavioural model.
module tb_btn_step_counter;

    localparam int DB   = 4;
    localparam int MAXC = 5;
    localparam int RD   = 20;
    localparam int RP   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_up = 1'b0;
    logic btn_dn = 1'b0;
    logic btn_clr = 1'b0;

    logic [2:0] cnt_w, cnt_s;
    logic [5:0] oh_w, oh_s;
    logic led_w, led_s, step_w, step_s, wrap_w, wrap_s;

    always #5 clk = ~clk;

    btn_step_counter #(
        .DEBOUNCE_CYCLES(DB), .CNT_MAX(MAXC), .CNT_W(3), .WRAP(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_w (
        .i_clk(clk), .i_rst(rst), .i_btn_up(btn_up), .i_btn_dn(btn_dn),
        .i_btn_clr(btn_clr), .o_count(cnt_w), .o_onehot(oh_w),
        .o_led(led_w), .o_step(step_w), .o_wrap(wrap_w)
    );

    btn_step_counter #(
        .DEBOUNCE_CYCLES(DB), .CNT_MAX(MAXC), .CNT_W(3), .WRAP(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_s (
        .i_clk(clk), .i_rst(rst), .i_btn_up(btn_up), .i_btn_dn(btn_dn),
        .i_btn_clr(btn_clr), .o_count(cnt_s), .o_onehot(oh_s),
        .o_led(led_s), .o_step(step_s), .o_wrap(wrap_s)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: index 0 = up, 1 = down, 2 = clear; model 0 wraps, model 1 saturates.
    bit s1[3], s2[3], lvl[3], lvlq[3];
    int run[3];
    int mcnt[2], age[2], hdir[2];
    bit mstep[2], mwrap[2];
    bit ru, rdn, rc;
    bit raw[3];

    task automatic bump(input int m, input int d);
        if (d == 0) begin
            if (mcnt[m] < MAXC) begin mcnt[m]++; mstep[m] = 1; end
            else if (m == 0) begin mcnt[m] = 0; mstep[m] = 1; mwrap[m] = 1; end
        end else begin
            if (mcnt[m] > 0) begin mcnt[m]--; mstep[m] = 1; end
            else if (m == 0) begin mcnt[m] = MAXC; mstep[m] = 1; mwrap[m] = 1; end
        end
    endtask

    task automatic model_cycle(input int m);
        mstep[m] = 0;
        mwrap[m] = 0;
        if (rc) begin
            if (mcnt[m] != 0) mstep[m] = 1;
            mcnt[m] = 0;
            age[m]  = -1;
        end else if (age[m] < 0) begin
            if (ru != rdn) begin
                bump(m, rdn ? 1 : 0);
                hdir[m] = rdn ? 1 : 0;
                age[m]  = 0;
            end
        end else if (!lvl[hdir[m]]) begin
            age[m] = -1;
        end else begin
            age[m]++;
            if (age[m] == RD || (age[m] > RD && (age[m] - RD) % RP == 0))
                bump(m, hdir[m]);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                s1[i] = 0; s2[i] = 0; lvl[i] = 0; lvlq[i] = 0; run[i] = 0;
            end
            for (int m = 0; m < 2; m++) begin
                mcnt[m] = 0; age[m] = -1; hdir[m] = 0; mstep[m] = 0; mwrap[m] = 0;
            end
        end else begin
            ru  = lvl[0] & ~lvlq[0];
            rdn = lvl[1] & ~lvlq[1];
            rc  = lvl[2] & ~lvlq[2];
            for (int m = 0; m < 2; m++) model_cycle(m);
            raw[0] = btn_up; raw[1] = btn_dn; raw[2] = btn_clr;
            for (int i = 0; i < 3; i++) begin
                lvlq[i] = lvl[i];
                if (s2[i] != lvl[i]) begin
                    run[i]++;
                    if (run[i] == DB) begin lvl[i] = ~lvl[i]; run[i] = 0; end
                end else begin
                    run[i] = 0;
                end
                s2[i] = s1[i];
                s1[i] = raw[i];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("w_count",  int'(cnt_w),  mcnt[0]);
            chk("w_onehot", int'(oh_w),   1 << mcnt[0]);
            chk("w_led",    int'(led_w),  int'(lvl[0] | lvl[1] | lvl[2]));
            chk("w_step",   int'(step_w), int'(mstep[0]));
            chk("w_wrap",   int'(wrap_w), int'(mwrap[0]));
            chk("s_count",  int'(cnt_s),  mcnt[1]);
            chk("s_onehot", int'(oh_s),   1 << mcnt[1]);
            chk("s_led",    int'(led_s),  int'(lvl[0] | lvl[1] | lvl[2]));
            chk("s_step",   int'(step_s), int'(mstep[1]));
            chk("s_wrap",   int'(wrap_s), int'(mwrap[1]));
        end
    end

    // Pulse tallies and step timestamps used by the literal checks.
    int cyc = 0;
    int nsw = 0, nww = 0, nss = 0, nws = 0;
    int stq[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            nsw += int'(step_w);
            nww += int'(wrap_w);
            nss += int'(step_s);
            nws += int'(wrap_s);
            if (step_w) stq.push_back(cyc);
        end
    end

    task automatic press(input bit u, input bit d, input bit c);
        @(negedge clk);
        btn_up = u; btn_dn = d; btn_clr = c;
        repeat (DB + 4) @(negedge clk);
        btn_up = 0; btn_dn = 0; btn_clr = 0;
        repeat (DB + 6) @(negedge clk);
    endtask

    int b_sw, b_ww, b_ss, b_ws;
    int exp_w[6] = '{1, 2, 3, 4, 5, 0};
    int exp_s[6] = '{1, 2, 3, 4, 5, 5};

    task automatic snap();
        b_sw = nsw; b_ww = nww; b_ss = nss; b_ws = nws;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_count",  int'(cnt_w),  0);
        chk("rst_onehot", int'(oh_w),   1);
        chk("rst_led",    int'(led_w),  0);
        chk("rst_step",   int'(step_w), 0);
        chk("rst_wrap",   int'(wrap_w), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Glitches of 3 cycles must be rejected.
        snap();
        for (int g = 0; g < 5; g++) begin
            btn_up = 1; repeat (3) @(negedge clk);
            btn_up = 0; repeat (3) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        chk("t1_glitch_cnt",  int'(cnt_w), 0);
        chk("t1_glitch_step", nsw - b_sw, 0);
        btn_up = 1;
        repeat (6) @(negedge clk);
        chk("t1_lat6_cnt", int'(cnt_w), 0);
        @(negedge clk);
        chk("t1_lat7_cnt",  int'(cnt_w),  1);
        chk("t1_lat7_step", int'(step_w), 1);
        chk("t1_onehot",    int'(oh_w),   6'b000010);
        repeat (3) @(negedge clk);
        btn_up = 0;
        repeat (12) @(negedge clk);
        chk("t1_one_step", nsw - b_sw, 1);

        // Six ups from zero: wrapping vs saturating.
        press(0, 0, 1);
        chk("t2_clr_w", int'(cnt_w), 0);
        for (int i = 0; i < 6; i++) begin
            snap();
            press(1, 0, 0);
            chk("t2_up_cnt_w",  int'(cnt_w), exp_w[i]);
            chk("t2_up_wrap_w", nww - b_ww, (i == 5) ? 1 : 0);
            chk("t3_up_cnt_s",  int'(cnt_s), exp_s[i]);
            chk("t3_up_step_s", nss - b_ss, (i < 5) ? 1 : 0);
        end
        snap();
        press(0, 1, 0);
        chk("t2_dn_cnt_w",  int'(cnt_w), 5);
        chk("t2_dn_wrap_w", nww - b_ww, 1);
        chk("t3_dn_cnt_s",  int'(cnt_s), 4);
        press(0, 0, 1);
        snap();
        press(0, 1, 0);
        chk("t3_sat0_cnt_s",  int'(cnt_s), 0);
        chk("t3_sat0_step_s", nss - b_ss, 0);
        chk("t3_sat0_wrap_s", nws - b_ws, 0);
        chk("t2_dn0_cnt_w",   int'(cnt_w), 5);

        // Simultaneous up+down, then clear together with up.
        snap();
        press(1, 1, 0);
        chk("t5_updn_cnt_w",  int'(cnt_w), 5);
        chk("t5_updn_step_w", nsw - b_sw, 0);
        press(1, 0, 1);
        chk("t5_clrup_cnt_w", int'(cnt_w), 0);
        chk("t5_clrup_cnt_s", int'(cnt_s), 0);
        press(1, 0, 0);
        chk("t5_after_cnt_w", int'(cnt_w), 1);

        // Hold for auto-repeat.
        stq.delete();
        @(negedge clk);
        btn_up = 1;
        repeat (7 + 60) @(negedge clk);
        btn_up = 0;
        repeat (12) @(negedge clk);
        chk("t4_nsteps_ge3", int'(stq.size() >= 3), 1);
        chk("t4_first_gap",  (stq.size() >= 2) ? stq[1] - stq[0] : -1, 20);
        chk("t4_second_gap", (stq.size() >= 3) ? stq[2] - stq[1] : -1, 5);
        snap();
        repeat (40) @(negedge clk);
        chk("t4_quiet", nsw - b_sw, 0);

        // Reset in the middle of a hold.
        press(0, 0, 1);
        press(1, 0, 0);
        press(1, 0, 0);
        @(negedge clk);
        btn_up = 1;
        repeat (12) @(negedge clk);
        chk("t6_pre_cnt", int'(cnt_w), 3);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_cnt",    int'(cnt_w),  0);
        chk("t6_rst_onehot", int'(oh_w),   1);
        chk("t6_rst_led",    int'(led_w),  0);
        chk("t6_rst_step",   int'(step_w), 0);
        chk("t6_rst_wrap",   int'(wrap_w), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_lat6_cnt", int'(cnt_w), 0);
        @(negedge clk);
        chk("t6_lat7_cnt",  int'(cnt_w),  1);
        chk("t6_lat7_step", int'(step_w), 1);
        repeat (3) @(negedge clk);
        btn_up = 0;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
